serial_subtractor: RTL

//  Multi-cycle, parametrised N-bit subtractor: D = A - B - Bin, plus borrow-out.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 136 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial subtractor.
// The requester owns start and the operands; the subtractor owns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             zero;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, zero
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor D = A - B - Bin with borrow-out, processed LSB first
// DIGIT bits per clock through a registered borrow chain.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bw_q, bw_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT:0]       slice;
    logic [WIDTH+DIGIT-1:0] res_ext;
    logic [WIDTH-1:0]     res_shift;

    // Ripple of DIGIT full-subtractor cells; returns {borrow_out, difference}.
    function automatic logic [DIGIT:0] sub_slice(
        input logic [DIGIT-1:0] a,
        input logic [DIGIT-1:0] b,
        input logic             bw_in
    );
        logic [DIGIT-1:0] d;
        logic             bw;
        bw = bw_in;
        d  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = a[i] ^ b[i] ^ bw;
            bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        return {bw, d};
    endfunction

    assign slice     = sub_slice(a_q[DIGIT-1:0], b_q[DIGIT-1:0], bw_q);
    // New slice enters at the MSB end; the widened concat keeps DIGIT == WIDTH legal.
    assign res_ext   = {slice[DIGIT-1:0], res_q};
    assign res_shift = res_ext[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        bw_d    = bw_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    bw_d    = bus.Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                bw_d  = slice[DIGIT];
                res_d = res_shift;
                if (cnt_q == CNT_W'(N - 1)) begin
                    d_d     = res_shift;
                    bout_d  = slice[DIGIT];
                    zero_d  = (res_shift == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.zero = zero_q;
endmodule
